// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a streaming valid/ready interface.
// Each stage resolves one GROUP-bit lookahead group and registers that group's carry-out.
module pipelined_cla_adder #(
  parameter  int WIDTH = 16,
  parameter  int GROUP = 4,
  localparam int NG    = WIDTH / GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [NG-1:0]    valid_q;
  logic [NG-1:0]    carry_q;
  logic             ovf_q;
  logic [WIDTH-1:0] a_q   [NG];
  logic [WIDTH-1:0] b_q   [NG];
  logic [WIDTH-1:0] sum_q [NG];

  logic [NG-1:0]    load;
  logic [NG-1:0]    stage_vld_in;
  logic [NG-1:0]    c_in;
  logic [NG-1:0]    carry_d;
  logic             msb_carry;
  logic             ovf_d;
  logic [WIDTH-1:0] op_a   [NG];
  logic [WIDTH-1:0] op_b   [NG];
  logic [WIDTH-1:0] sum_in [NG];
  logic [WIDTH-1:0] sum_d  [NG];
  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP:0]   carries;

  // Two-level lookahead: each carry is a sum of products over g/p and the group carry-in.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             carry_in);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = carry_in;
    for (int i = 0; i < GROUP; i++) begin
      term = carry_in;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // A stage may load if it is empty or everything downstream of it moves this cycle.
  always_comb begin : p_load
    logic chain;
    load  = '0;
    chain = out_ready;
    for (int k = NG - 1; k >= 0; k--) begin
      chain   = chain | ~valid_q[k];
      load[k] = chain;
    end
  end

  always_comb begin
    op_a         = '{default: '0};
    op_b         = '{default: '0};
    sum_in       = '{default: '0};
    sum_d        = '{default: '0};
    c_in         = '0;
    carry_d      = '0;
    stage_vld_in = '0;
    gen          = '0;
    prop         = '0;
    carries      = '0;
    msb_carry    = 1'b0;

    op_a[0]         = a;
    op_b[0]         = sub ? ~b : b;
    c_in[0]         = cin ^ sub;
    stage_vld_in[0] = in_valid;
    for (int k = 1; k < NG; k++) begin
      op_a[k]         = a_q[k-1];
      op_b[k]         = b_q[k-1];
      sum_in[k]       = sum_q[k-1];
      c_in[k]         = carry_q[k-1];
      stage_vld_in[k] = valid_q[k-1];
    end

    for (int k = 0; k < NG; k++) begin
      gen      = op_a[k][k*GROUP +: GROUP] & op_b[k][k*GROUP +: GROUP];
      prop     = op_a[k][k*GROUP +: GROUP] ^ op_b[k][k*GROUP +: GROUP];
      carries  = cla_carries(gen, prop, c_in[k]);
      sum_d[k] = sum_in[k];
      sum_d[k][k*GROUP +: GROUP] = prop ^ carries[GROUP-1:0];
      carry_d[k] = carries[GROUP];
      msb_carry  = carries[GROUP-1];
    end
  end

  assign ovf_d = msb_carry ^ carry_d[NG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NG; k++) begin
        if (load[k]) begin
          valid_q[k] <= stage_vld_in[k];
          if (stage_vld_in[k]) begin
            a_q[k]     <= op_a[k];
            b_q[k]     <= op_b[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
      if (load[NG-1] && stage_vld_in[NG-1]) ovf_q <= ovf_d;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[NG-1];
  assign sum       = sum_q[NG-1];
  assign cout      = carry_q[NG-1];
  assign ovf       = ovf_q;

endmodule
